// File: rtl/tick_timer_scheduler_if.sv
// Request/acknowledge bundle between interval requesters and the tick timer scheduler.
// Channel k length is carried at len[k*LEN_W +: LEN_W].
interface tick_timer_scheduler_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned LEN_W = 16
);
    logic [N_CH-1:0]       req;
    logic [N_CH*LEN_W-1:0] len;
    logic [N_CH-1:0]       ack;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       expire;

    modport master (output req, len, input ack, busy, expire);
    modport slave  (input req, len, output ack, busy, expire);
endinterface

// File: rtl/tick_timer_scheduler.sv
// One prescaled tick shared by N_CH one-shot interval timers.
// Requests are admitted one per cycle by a round-robin arbiter.
module tick_timer_scheduler #(
    parameter int unsigned PRESCALE = 2500,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned N_CH     = 4,
    parameter int unsigned LEN_W    = 16
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  en_i,
    output logic                  tick_o,
    tick_timer_scheduler_if.slave tmr
);
    localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [N_CH-1:0]  ack_q, ack_d;
    logic [N_CH-1:0]  busy_q, busy_d;
    logic [N_CH-1:0]  expire_q, expire_d;
    logic [LEN_W-1:0] rem_q [N_CH];
    logic [LEN_W-1:0] rem_d [N_CH];
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [N_CH-1:0]  eligible;
    logic             found;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] scan_idx;
    logic [LEN_W-1:0] grant_len;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (en_i) begin
            if (cnt_q == CNT_W'(PRESCALE)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Busy channels are masked out, so a channel cannot be re-granted in its expire cycle.
    always_comb begin
        eligible  = tmr.req & ~busy_q;
        found     = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + i) % int'(N_CH));
            if (!found && eligible[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
        grant_len = tmr.len[int'(grant_idx)*LEN_W +: LEN_W];
    end

    always_comb begin
        ack_d    = '0;
        expire_d = '0;
        busy_d   = busy_q;
        rem_d    = rem_q;
        rr_ptr_d = rr_ptr_q;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (busy_q[k] && tick_q) begin
                if (rem_q[k] == LEN_W'(1)) begin
                    busy_d[k]   = 1'b0;
                    expire_d[k] = 1'b1;
                    rem_d[k]    = '0;
                end else begin
                    rem_d[k] = rem_q[k] - 1'b1;
                end
            end
        end
        if (found) begin
            ack_d[grant_idx] = 1'b1;
            rr_ptr_d         = PTR_W'((int'(grant_idx) + 1) % int'(N_CH));
            if (grant_len != '0) begin
                busy_d[grant_idx] = 1'b1;
                rem_d[grant_idx]  = grant_len;
            end else begin
                expire_d[grant_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            ack_q    <= '0;
            busy_q   <= '0;
            expire_q <= '0;
            rr_ptr_q <= '0;
            for (int k = 0; k < int'(N_CH); k++) begin
                rem_q[k] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            expire_q <= expire_d;
            rr_ptr_q <= rr_ptr_d;
            rem_q    <= rem_d;
        end
    end

    assign tick_o     = tick_q;
    assign tmr.ack    = ack_q;
    assign tmr.busy   = busy_q;
    assign tmr.expire = expire_q;
endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Directed and randomized checks of tick_timer_scheduler against a cycle-level
// behavioural model of the time base, round-robin admission and interval countdown.
module tb_tick_timer_scheduler;
    localparam int P  = 3;
    localparam int N  = 4;
    localparam int LW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic tick;

    tick_timer_scheduler_if #(.N_CH(N), .LEN_W(LW)) bus ();

    tick_timer_scheduler #(
        .PRESCALE(P),
        .CNT_W   (32),
        .N_CH    (N),
        .LEN_W   (LW)
    ) dut (
        .clock_i(clk),
        .reset_i(rst_n),
        .en_i   (en),
        .tick_o (tick),
        .tmr    (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: time base position, pointer and ticks still owed per channel.
    int         m_cnt;
    int         m_rr;
    bit         m_tick;
    bit [N-1:0] m_ack, m_busy, m_exp;
    int         m_left [N];
    bit [N-1:0] hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int         n_cnt, n_rr, g, l;
        bit         n_tick;
        bit [N-1:0] n_ack, n_busy, n_exp, elig;
        int         n_left [N];
        n_cnt = 0; n_rr = 0; n_tick = 0; n_ack = '0; n_busy = '0; n_exp = '0;
        for (int k = 0; k < N; k++) n_left[k] = 0;
        if (rst_n) begin
            n_tick = en && (m_cnt == P);
            n_cnt  = !en ? m_cnt : ((m_cnt == P) ? 0 : m_cnt + 1);
            n_busy = m_busy;
            n_left = m_left;
            n_rr   = m_rr;
            for (int k = 0; k < N; k++) begin
                if (m_busy[k] && m_tick) begin
                    n_left[k] = n_left[k] - 1;
                    if (n_left[k] == 0) begin
                        n_busy[k] = 1'b0;
                        n_exp[k]  = 1'b1;
                    end
                end
            end
            elig = bus.req & ~m_busy;
            g = -1;
            for (int i = 0; i < N; i++)
                if (g < 0 && elig[(m_rr + i) % N]) g = (m_rr + i) % N;
            if (g >= 0) begin
                n_ack[g] = 1'b1;
                n_rr     = (g + 1) % N;
                l        = int'(bus.len[g*LW +: LW]);
                if (l == 0) n_exp[g] = 1'b1;
                else begin
                    n_busy[g] = 1'b1;
                    n_left[g] = l;
                end
            end
        end
        @(posedge clk);
        #1;
        m_cnt = n_cnt; m_rr = n_rr; m_tick = n_tick;
        m_ack = n_ack; m_busy = n_busy; m_exp = n_exp; m_left = n_left;
        chk("tick",   32'(tick),       32'(m_tick));
        chk("ack",    32'(bus.ack),    32'(m_ack));
        chk("busy",   32'(bus.busy),   32'(m_busy));
        chk("expire", 32'(bus.expire), 32'(m_exp));
        bus.req = bus.req & ~(bus.ack & ~hold);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bus.req = '0;
        bus.len = '0;
        hold    = '0;
        m_cnt = 0; m_rr = 0; m_tick = 0; m_ack = '0; m_busy = '0; m_exp = '0;
        for (int k = 0; k < N; k++) m_left[k] = 0;

        // Reset held with every channel requesting: nothing may respond.
        rst_n   = 1'b0;
        bus.req = 4'hF;
        for (int k = 0; k < N; k++) bus.len[k*LW +: LW] = 16'd5;
        hold    = 4'hF;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_ack", 32'(bus.ack), 32'd0);
            chk("rst_tick", 32'(tick), 32'd0);
        end

        // Free-running time base, then frozen from cycle 9.
        hold    = '0;
        bus.req = '0;
        rst_n   = 1'b1;
        en      = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cycle();
            chk("tick_period", 32'(tick), 32'((c % 4) == 0));
        end
        en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            chk("tick_frozen", 32'(tick), 32'd0);
        end
        en = 1'b1;
        run(10);

        // Burst request from all channels: fair order from pointer 0.
        bus.req = 4'hF;
        for (int i = 0; i < N; i++) begin
            cycle();
            chk("ack_order", 32'(bus.ack), 32'(1 << i));
        end
        bus.req = 4'b0101;
        run(40);

        // Single two-tick interval on channel 1.
        bus.len[1*LW +: LW] = 16'd2;
        bus.req[1] = 1'b1;
        run(16);

        // Zero length completes in the grant cycle without going busy.
        bus.len[3*LW +: LW] = 16'd0;
        bus.req[3] = 1'b1;
        cycle();
        chk("zero_ack", 32'(bus.ack[3]), 32'd1);
        chk("zero_exp", 32'(bus.expire[3]), 32'd1);
        run(4);

        // Reset mid-countdown drops the interval silently; max length runs alongside.
        bus.len[2*LW +: LW] = 16'd5;
        bus.len[0*LW +: LW] = 16'hFFFF;
        bus.req[2] = 1'b1;
        bus.req[0] = 1'b1;
        for (int i = 0; i < 40; i++)
            if (!(m_busy[2] && m_left[2] == 3)) cycle();
        chk("rem3_reached", 32'(m_busy[2] && m_left[2] == 3), 32'd1);
        bus.req = '0;
        rst_n   = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("no_drop_exp", 32'(bus.expire), 32'd0);
        end
        bus.len[2*LW +: LW] = 16'd2;
        bus.req[2] = 1'b1;
        cycle();
        chk("reaccept", 32'(bus.ack[2]), 32'd1);
        run(14);

        // Random traffic: auto-repeat, dropped requests, stray length changes, rare resets.
        for (int i = 0; i < 900; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
            for (int k = 0; k < N; k++) begin
                if (!bus.req[k]) begin
                    bus.len[k*LW +: LW] = 16'($urandom_range(0, 4));
                    if ($urandom_range(0, 3) == 0) begin
                        bus.req[k] = 1'b1;
                        hold[k]    = 1'($urandom_range(0, 1));
                    end
                end else if (bus.busy[k] && $urandom_range(0, 7) == 0) begin
                    bus.req[k] = 1'b0;
                    hold[k]    = 1'b0;
                end
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
